// File: rtl/flp_adder_multilane.sv
// flp_adder_multilane: LANES independent IEEE-754 style adders/subtractors sharing one valid
// stream. Fully pipelined, one request per cycle, fixed latency of 4 cycles from the edge that
// samples in_valid to the edge that presents out_valid/result. Round-to-nearest-even,
// subnormals flushed to zero, sticky per-lane exception flags.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset (clears valids, result, flags)
//   in_valid   request valid, sampled every cycle
//   op_sub     per lane: 1 = a - b, 0 = a + b
//   a, b       operands, lane i at [i*W +: W], W = 1+EXP_BITS+SIG_BITS
//   result     registered results, held while out_valid = 0
//   out_valid  result valid
//   clr_flags  clears sticky flags; sampled on the same edge that registers a result, in which
//              case the flags become exactly that result's flags
//   flags      per lane {invalid, overflow, underflow, inexact} at [i*4 +: 4]
module flp_adder_multilane #(
    parameter int unsigned EXP_BITS = 11,
    parameter int unsigned SIG_BITS = 52,
    parameter int unsigned LANES    = 1
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   in_valid,
    input  logic [LANES-1:0]                       op_sub,
    input  logic [LANES*(1+EXP_BITS+SIG_BITS)-1:0] a,
    input  logic [LANES*(1+EXP_BITS+SIG_BITS)-1:0] b,
    output logic [LANES*(1+EXP_BITS+SIG_BITS)-1:0] result,
    output logic                                   out_valid,
    input  logic                                   clr_flags,
    output logic [4*LANES-1:0]                     flags
);
    localparam int unsigned E   = EXP_BITS;
    localparam int unsigned M   = SIG_BITS;
    localparam int unsigned W   = 1 + E + M;
    localparam int unsigned MW  = M + 4;                      // hidden, fraction, G, R, S
    localparam int unsigned RW  = M + 2;                      // rounded significand + carry
    localparam int unsigned SHW = $clog2(M + 4);              // holds shift/lzc 0..M+3
    localparam int unsigned EW  = ((E > SHW) ? E : SHW) + 2;  // signed working exponent
    localparam logic [31:0] MAX_SH = 32'(M + 3);
    localparam logic [EW-1:0] EXP_ONES = {{(EW-E){1'b0}}, {E{1'b1}}};

    // ---------------- shared control ----------------
    logic             in_valid_d, in_valid_q;
    logic             s1_valid_d, s1_valid_q;
    logic             s2_valid_d, s2_valid_q;
    logic             s3_valid_d, s3_valid_q;
    logic             out_valid_d, out_valid_q;
    logic [LANES-1:0] op_sub_d, op_sub_q;
    logic [LANES*W-1:0] a_d, a_q, b_d, b_q;

    always_comb begin
        in_valid_d  = in_valid;
        s1_valid_d  = in_valid_q;
        s2_valid_d  = s1_valid_q;
        s3_valid_d  = s2_valid_q;
        out_valid_d = s3_valid_q;
        // Operands only load on a request to avoid needless toggling downstream.
        op_sub_d    = in_valid ? op_sub : op_sub_q;
        a_d         = in_valid ? a : a_q;
        b_d         = in_valid ? b : b_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            in_valid_q  <= 1'b0;
            s1_valid_q  <= 1'b0;
            s2_valid_q  <= 1'b0;
            s3_valid_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            in_valid_q  <= in_valid_d;
            s1_valid_q  <= s1_valid_d;
            s2_valid_q  <= s2_valid_d;
            s3_valid_q  <= s3_valid_d;
            out_valid_q <= out_valid_d;
        end
        op_sub_q <= op_sub_d;
        a_q      <= a_d;
        b_q      <= b_d;
    end

    assign out_valid = out_valid_q;

    // ---------------- per-lane datapath ----------------
    for (genvar i = 0; i < LANES; i++) begin : g_lane
        // S1: unpack, specials, swap so |large| >= |small|
        logic         sa, sb, sbe;
        logic [E-1:0] ea, eb;
        logic [M-1:0] fa, fb;
        logic         a_zero, b_zero, a_nan, b_nan, a_inf, b_inf, swap;
        logic [M:0]   siga, sigb;
        logic [E+M-1:0] mag_a, mag_b;

        logic         s1_sign_l_d, s1_sign_l_q, s1_eff_sub_d, s1_eff_sub_q;
        logic         s1_nan_d, s1_nan_q, s1_invalid_d, s1_invalid_q;
        logic         s1_inf_d, s1_inf_q, s1_inf_sign_d, s1_inf_sign_q;
        logic [E-1:0] s1_exp_l_d, s1_exp_l_q, s1_diff_d, s1_diff_q;
        logic [M:0]   s1_sig_l_d, s1_sig_l_q, s1_sig_s_d, s1_sig_s_q;

        assign {sa, ea, fa} = a_q[i*W +: W];
        assign {sb, eb, fb} = b_q[i*W +: W];

        always_comb begin
            sbe    = sb ^ op_sub_q[i];
            a_zero = (ea == '0);
            b_zero = (eb == '0);
            a_nan  = (&ea) & (|fa);
            b_nan  = (&eb) & (|fb);
            a_inf  = (&ea) & ~(|fa);
            b_inf  = (&eb) & ~(|fb);
            // Exponent 0 is flushed: hidden bit and fraction both dropped.
            siga   = a_zero ? '0 : {1'b1, fa};
            sigb   = b_zero ? '0 : {1'b1, fb};
            mag_a  = a_zero ? '0 : {ea, fa};
            mag_b  = b_zero ? '0 : {eb, fb};
            swap   = (mag_b > mag_a);

            s1_sign_l_d   = swap ? sbe : sa;
            s1_eff_sub_d  = sa ^ sbe;
            s1_exp_l_d    = swap ? eb : ea;
            s1_diff_d     = swap ? (eb - ea) : (ea - eb);
            s1_sig_l_d    = swap ? sigb : siga;
            s1_sig_s_d    = swap ? siga : sigb;
            s1_invalid_d  = a_inf & b_inf & (sa ^ sbe);
            s1_nan_d      = a_nan | b_nan | s1_invalid_d;
            s1_inf_d      = a_inf | b_inf;
            s1_inf_sign_d = a_inf ? sa : sbe;
        end

        // S2: align small operand, keep guard/round and an OR of everything shifted past them
        logic [31:0]  diff_ext;
        logic [SHW-1:0] sh;
        logic [M+2:0] s_ext, shifted, mask;
        logic         sticky;

        logic          s2_sign_l_d, s2_sign_l_q, s2_eff_sub_d, s2_eff_sub_q;
        logic          s2_nan_d, s2_nan_q, s2_invalid_d, s2_invalid_q;
        logic          s2_inf_d, s2_inf_q, s2_inf_sign_d, s2_inf_sign_q;
        logic [E-1:0]  s2_exp_l_d, s2_exp_l_q;
        logic [MW-1:0] s2_mag_l_d, s2_mag_l_q, s2_mag_s_d, s2_mag_s_q;

        always_comb begin
            diff_ext = 32'(s1_diff_q);
            sh       = (diff_ext > MAX_SH) ? MAX_SH[SHW-1:0] : diff_ext[SHW-1:0];
            s_ext    = {s1_sig_s_q, 2'b00};
            shifted  = s_ext >> sh;
            mask     = ~({(M+3){1'b1}} << sh);
            sticky   = |(s_ext & mask);

            s2_sign_l_d   = s1_sign_l_q;
            s2_eff_sub_d  = s1_eff_sub_q;
            s2_exp_l_d    = s1_exp_l_q;
            s2_mag_l_d    = {s1_sig_l_q, 3'b000};
            s2_mag_s_d    = {shifted, sticky};
            s2_nan_d      = s1_nan_q;
            s2_invalid_d  = s1_invalid_q;
            s2_inf_d      = s1_inf_q;
            s2_inf_sign_d = s1_inf_sign_q;
        end

        // S3: add/subtract magnitudes, leading-zero count, normalise
        logic [MW:0]    sum;
        logic [SHW-1:0] lz;
        logic           found;

        logic          s3_sign_d, s3_sign_q, s3_zero_d, s3_zero_q;
        logic          s3_nan_d, s3_nan_q, s3_invalid_d, s3_invalid_q;
        logic          s3_inf_d, s3_inf_q, s3_inf_sign_d, s3_inf_sign_q;
        logic [EW-1:0] s3_exp_d, s3_exp_q;
        logic [MW-1:0] s3_mant_d, s3_mant_q;

        always_comb begin
            if (s2_eff_sub_q) sum = {1'b0, s2_mag_l_q} - {1'b0, s2_mag_s_q};
            else              sum = {1'b0, s2_mag_l_q} + {1'b0, s2_mag_s_q};

            lz    = '0;
            found = 1'b0;
            for (int k = MW - 1; k >= 0; k--) begin
                if (!found) begin
                    if (sum[k]) found = 1'b1;
                    else        lz    = lz + SHW'(1);
                end
            end

            s3_zero_d = (sum == '0);
            // Exact cancellation yields +0; same-sign zero sums keep their sign.
            s3_sign_d = (s3_zero_d & s2_eff_sub_q) ? 1'b0 : s2_sign_l_q;
            if (sum[MW]) begin
                s3_mant_d = {sum[MW:2], sum[1] | sum[0]};
                s3_exp_d  = EW'(s2_exp_l_q) + EW'(1);
            end else begin
                s3_mant_d = sum[MW-1:0] << lz;
                s3_exp_d  = EW'(s2_exp_l_q) - EW'(lz);
            end
            s3_nan_d      = s2_nan_q;
            s3_invalid_d  = s2_invalid_q;
            s3_inf_d      = s2_inf_q;
            s3_inf_sign_d = s2_inf_sign_q;
        end

        // S4: round-nearest-even, range checks, pack, flags
        logic          rnd_up, carry, inexact;
        logic [RW-1:0] rounded;
        logic [M-1:0]  frac;
        logic [EW-1:0] exp_r;
        logic [W-1:0]  lane_res, res_d, res_q;
        logic [3:0]    lane_flg, flg_d, flg_q;

        always_comb begin
            rnd_up  = s3_mant_q[2] & (s3_mant_q[1] | s3_mant_q[0] | s3_mant_q[3]);
            rounded = {1'b0, s3_mant_q[MW-1:3]} + RW'(rnd_up);
            carry   = rounded[M+1];
            frac    = carry ? rounded[M:1] : rounded[M-1:0];
            exp_r   = s3_exp_q + EW'(carry);
            inexact = |s3_mant_q[2:0];

            lane_res = {s3_sign_q, exp_r[E-1:0], frac};
            lane_flg = {3'b000, inexact};
            if (s3_nan_q) begin
                lane_res = {1'b0, {E{1'b1}}, 1'b1, {(M-1){1'b0}}};
                lane_flg = {s3_invalid_q, 3'b000};
            end else if (s3_inf_q) begin
                lane_res = {s3_inf_sign_q, {E{1'b1}}, {M{1'b0}}};
                lane_flg = 4'b0000;
            end else if (s3_zero_q) begin
                lane_res = {s3_sign_q, {(W-1){1'b0}}};
                lane_flg = 4'b0000;
            end else if ($signed(exp_r) <= 0) begin
                lane_res = {s3_sign_q, {(W-1){1'b0}}};
                lane_flg = 4'b0011;
            end else if ($signed(exp_r) >= $signed(EXP_ONES)) begin
                lane_res = {s3_sign_q, {E{1'b1}}, {M{1'b0}}};
                lane_flg = 4'b0101;
            end

            res_d = s3_valid_q ? lane_res : res_q;
            if (clr_flags)       flg_d = s3_valid_q ? lane_flg : 4'b0000;
            else if (s3_valid_q) flg_d = flg_q | lane_flg;
            else                 flg_d = flg_q;
        end

        always_ff @(posedge clk) begin
            s1_sign_l_q   <= s1_sign_l_d;
            s1_eff_sub_q  <= s1_eff_sub_d;
            s1_exp_l_q    <= s1_exp_l_d;
            s1_diff_q     <= s1_diff_d;
            s1_sig_l_q    <= s1_sig_l_d;
            s1_sig_s_q    <= s1_sig_s_d;
            s1_nan_q      <= s1_nan_d;
            s1_invalid_q  <= s1_invalid_d;
            s1_inf_q      <= s1_inf_d;
            s1_inf_sign_q <= s1_inf_sign_d;

            s2_sign_l_q   <= s2_sign_l_d;
            s2_eff_sub_q  <= s2_eff_sub_d;
            s2_exp_l_q    <= s2_exp_l_d;
            s2_mag_l_q    <= s2_mag_l_d;
            s2_mag_s_q    <= s2_mag_s_d;
            s2_nan_q      <= s2_nan_d;
            s2_invalid_q  <= s2_invalid_d;
            s2_inf_q      <= s2_inf_d;
            s2_inf_sign_q <= s2_inf_sign_d;

            s3_sign_q     <= s3_sign_d;
            s3_zero_q     <= s3_zero_d;
            s3_exp_q      <= s3_exp_d;
            s3_mant_q     <= s3_mant_d;
            s3_nan_q      <= s3_nan_d;
            s3_invalid_q  <= s3_invalid_d;
            s3_inf_q      <= s3_inf_d;
            s3_inf_sign_q <= s3_inf_sign_d;

            if (rst) begin
                res_q <= '0;
                flg_q <= '0;
            end else begin
                res_q <= res_d;
                flg_q <= flg_d;
            end
        end

        assign result[i*W +: W] = res_q;
        assign flags[i*4 +: 4]  = flg_q;
    end

endmodule

// File: tb/tb_flp_adder_multilane.sv
// Directed bench for flp_adder_multilane with default double format and two lanes.
module tb_flp_adder_multilane;
    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic [1:0]   op_sub;
    logic [127:0] a, b, result;
    logic         out_valid;
    logic         clr_flags;
    logic [7:0]   flags;

    int n_cmp = 0;
    int n_err = 0;

    logic [63:0] ra [0:7][0:1];
    logic [63:0] rb [0:7][0:1];
    logic [63:0] rx [0:7][0:1];
    logic [1:0]  rs [0:7];

    always #5 clk = ~clk;

    flp_adder_multilane #(
        .EXP_BITS(11),
        .SIG_BITS(52),
        .LANES   (2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .op_sub   (op_sub),
        .a        (a),
        .b        (b),
        .result   (result),
        .out_valid(out_valid),
        .clr_flags(clr_flags),
        .flags    (flags)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Host doubles round to nearest even; operands are kept well inside the normal range.
    function automatic logic [63:0] ref_add(input logic [63:0] x, input logic [63:0] y,
                                            input logic sub);
        real fx, fy, fr;
        fx = $bitstoreal(x);
        fy = $bitstoreal(y);
        fr = sub ? (fx - fy) : (fx + fy);
        return $realtobits(fr);
    endfunction

    task automatic issue(input logic [1:0] sub, input logic [63:0] a0, input logic [63:0] b0,
                         input logic [63:0] a1, input logic [63:0] b1);
        in_valid = 1'b1;
        op_sub   = sub;
        a        = {a1, a0};
        b        = {b1, b0};
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_out(input string tag);
        for (int j = 1; j <= 3; j++) begin
            tick();
            chk({tag, "/early_valid"}, 64'(out_valid), 64'd0);
        end
        tick();
        chk({tag, "/valid"}, 64'(out_valid), 64'd1);
    endtask

    task automatic run(input string tag, input logic [1:0] sub,
                       input logic [63:0] a0, input logic [63:0] b0,
                       input logic [63:0] a1, input logic [63:0] b1,
                       input logic [63:0] e0, input logic [63:0] e1, input logic [7:0] ef);
        clr_flags = 1'b1;
        tick();
        clr_flags = 1'b0;
        issue(sub, a0, b0, a1, b1);
        wait_out(tag);
        chk({tag, "/lane0"}, result[63:0], e0);
        chk({tag, "/lane1"}, result[127:64], e1);
        chk({tag, "/flags"}, 64'(flags), 64'(ef));
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        clr_flags = 1'b0;
        op_sub    = 2'b00;
        a         = '0;
        b         = '0;
        tick();
        tick();
        chk("reset/out_valid", 64'(out_valid), 64'd0);
        chk("reset/lane0", result[63:0], 64'd0);
        chk("reset/lane1", result[127:64], 64'd0);
        chk("reset/flags", 64'(flags), 64'd0);
        rst = 1'b0;

        run("add_sub", 2'b10, 64'h3FF0000000000000, 64'h4000000000000000,
            64'h3FF0000000000000, 64'h3FF0000000000000,
            64'h4008000000000000, 64'h0000000000000000, 8'h00);
        run("tie_even", 2'b00, 64'h3FF0000000000000, 64'h3CA0000000000000,
            64'h3FF0000000000001, 64'h3CA0000000000000,
            64'h3FF0000000000000, 64'h3FF0000000000002, 8'h11);
        run("inf_ovf", 2'b00, 64'h7FF0000000000000, 64'hFFF0000000000000,
            64'h7FEFFFFFFFFFFFFF, 64'h7FEFFFFFFFFFFFFF,
            64'h7FF8000000000000, 64'h7FF0000000000000, 8'h58);
        run("nan_inf", 2'b10, 64'h7FF4000000000000, 64'h3FF0000000000000,
            64'hFFF0000000000000, 64'h3FF0000000000000,
            64'h7FF8000000000000, 64'hFFF0000000000000, 8'h00);
        run("negzero_unf", 2'b10, 64'h8000000000000000, 64'h8000000000000000,
            64'h0010000000000000, 64'h0010000000000001,
            64'h8000000000000000, 64'h8000000000000000, 8'h30);
        run("ftz_in", 2'b00, 64'h0000000000000001, 64'h3FF0000000000000,
            64'h8000000000000005, 64'h0000000000000003,
            64'h3FF0000000000000, 64'h0000000000000000, 8'h00);

        // Back-to-back random normals
        for (int j = 0; j < 8; j++) begin
            rs[j] = 2'($urandom_range(0, 3));
            for (int l = 0; l < 2; l++) begin
                ra[j][l] = {1'($urandom_range(0, 1)), 11'(11'h3F0 + 11'($urandom_range(0, 31))),
                            20'($urandom), 32'($urandom)};
                rb[j][l] = {1'($urandom_range(0, 1)), 11'(11'h3F0 + 11'($urandom_range(0, 31))),
                            20'($urandom), 32'($urandom)};
                rx[j][l] = ref_add(ra[j][l], rb[j][l], rs[j][l]);
            end
        end
        for (int k = 0; k < 12; k++) begin
            if (k < 8) begin
                in_valid = 1'b1;
                op_sub   = rs[k];
                a        = {ra[k][1], ra[k][0]};
                b        = {rb[k][1], rb[k][0]};
            end else begin
                in_valid = 1'b0;
            end
            tick();
            if (k < 4) begin
                chk("b2b/idle", 64'(out_valid), 64'd0);
            end else begin
                chk("b2b/valid", 64'(out_valid), 64'd1);
                chk("b2b/lane0", result[63:0], rx[k-4][0]);
                chk("b2b/lane1", result[127:64], rx[k-4][1]);
            end
        end
        tick();
        chk("b2b/drained", 64'(out_valid), 64'd0);

        // Clear coinciding with a valid overflow output
        issue(2'b00, 64'h7FF0000000000000, 64'hFFF0000000000000,
              64'h3FF0000000000000, 64'h4000000000000000);
        wait_out("pre_clr");
        chk("pre_clr/invalid", 64'(flags[3]), 64'd1);
        issue(2'b00, 64'h7FEFFFFFFFFFFFFF, 64'h7FEFFFFFFFFFFFFF,
              64'h3FF0000000000000, 64'h4000000000000000);
        for (int j = 1; j <= 3; j++) tick();
        clr_flags = 1'b1;
        tick();
        chk("clr_valid/valid", 64'(out_valid), 64'd1);
        chk("clr_valid/lane0", result[63:0], 64'h7FF0000000000000);
        chk("clr_valid/lane1", result[127:64], 64'h4008000000000000);
        chk("clr_valid/flags", 64'(flags), 64'h05);
        tick();
        chk("clr_only/flags", 64'(flags), 64'h00);
        chk("clr_only/hold", result[63:0], 64'h7FF0000000000000);
        clr_flags = 1'b0;

        // Reset with requests in flight
        run("pre_rst", 2'b00, 64'h3FF0000000000000, 64'h3CA0000000000000,
            64'h3FF0000000000001, 64'h3CA0000000000000,
            64'h3FF0000000000000, 64'h3FF0000000000002, 8'h11);
        in_valid = 1'b1;
        op_sub   = 2'b00;
        a        = {64'h3FF0000000000000, 64'h3FF0000000000000};
        b        = {64'h4000000000000000, 64'h4000000000000000};
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst      = 1'b0;
        in_valid = 1'b0;
        chk("rst/lane0", result[63:0], 64'd0);
        chk("rst/lane1", result[127:64], 64'd0);
        chk("rst/flags", 64'(flags), 64'd0);
        for (int j = 0; j < 6; j++) begin
            chk("rst/no_valid", 64'(out_valid), 64'd0);
            tick();
        end
        chk("rst/lane0_after", result[63:0], 64'd0);
        chk("rst/flags_after", 64'(flags), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/flp_adder_multilane.md
Name: flp_adder_multilane

Overview:
- Parametrised, fully pipelined IEEE-754 binary floating-point adder/subtractor for LANES independent lanes sharing one valid stream.
- Successor to the fixed-format single-lane adder:
  - configurable exponent and significand widths;
  - runtime per-request add/sub select;
  - round-to-nearest-even;
  - special-value handling (inf/NaN);
  - sticky exception flags.
- Sits in the floating-point datapath feeding the FFT/butterfly units; accepts one request per cycle, no backpressure.

Parameters:
- EXP_BITS, 11, exponent field width (≥4).
- SIG_BITS, 52, stored fraction width, without hidden bit (≥4).
- LANES, 1, number of parallel independent adders (≥1).
- W = 1+EXP_BITS+SIG_BITS (derived, not overridable).

Ports:
- clk  in  1  clock, all logic rising-edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  request valid; sampled every cycle.
- op_sub  in  LANES  per lane: 1 = a−b, 0 = a+b; sampled with in_valid.
- a  in  LANES*W  operand A, lane i at [i*W +: W].
- b  in  LANES*W  operand B, same packing.
- result  out  LANES*W  registered sums, same packing.
- out_valid  out  1  result valid.
- clr_flags  in  1  clears sticky flags.
- flags  out  4*LANES  sticky per lane {invalid, overflow, underflow, inexact}, lane i at [i*4 +: 4].

Behaviour:
- Latency: fixed 4 cycles. in_valid at edge n gives out_valid and result at edge n+4. Throughput is 1 request/cycle; no stall.
- Pipeline stages:
  - S1: unpack, special-case detect, swap so |A|≥|B|, compute exponent difference.
  - S2: align B, right-shifting by min(diff, SIG_BITS+3) while keeping guard, round and sticky (OR of all shifted-out bits).
  - S3: signed significand add, leading-zero count, normalise.
  - S4: round-nearest-even, exponent adjust, pack, flag update.
- Effective operation: eff_sub = sign(a) XOR sign(b) XOR op_sub.
- Subnormals are flushed to zero:
  - Input with exponent 0 is treated as signed zero.
  - Rounded result with biased exponent ≤0 becomes signed zero and sets underflow and inexact.
- Rounding: round up iff guard & (round | sticky | lsb). Significand carry-out after rounding increments the exponent.
- Overflow: rounded exponent ≥ all-ones gives ±inf; sets overflow and inexact.
- Specials:
  - Any NaN operand gives NaN.
  - inf with opposite effective-sign inf gives NaN and sets invalid.
  - inf with finite gives that inf.
  - Canonical NaN: sign 0, exponent all ones, fraction MSB 1, rest 0.
- Exact zero result:
  - +0, except when both effective operands are −0, which gives −0.
  - x − x gives +0.
- result holds its last value while out_valid=0. Flags update only on cycles where out_valid=1.
- Flags: flags[i] |= new flags each valid output.
  - clr_flags has priority: a clear in the same cycle as a valid output yields exactly that output's flags.
- Reset:
  - All valid pipeline bits, out_valid, result and flags go to 0 on the next edge.
  - In-flight requests are discarded, never emitted.
  - in_valid during rst is ignored.
- Lanes share control and are otherwise independent. A lane's flags never depend on another lane.

Test Plan:
- Default params, LANES=2.
  - Lane0: 0x3FF0000000000000 + 0x4000000000000000, expect 0x4008000000000000.
  - Lane1 (op_sub=1): 0x3FF0000000000000 − 0x3FF0000000000000, expect 0x0000000000000000.
  - Both results arrive exactly 4 cycles after in_valid; flags stay 0.
- Tie to even: 0x3FF0000000000000 + 0x3CA0000000000000 → 0x3FF0000000000000, inexact=1.
  - 0x3FF0000000000001 + 0x3CA0000000000000 → 0x3FF0000000000002.
- 0x7FF0000000000000 + 0xFFF0000000000000 → 0x7FF8000000000000, invalid=1.
  - 0x7FEFFFFFFFFFFFFF + 0x7FEFFFFFFFFFFFFF → 0x7FF0000000000000, overflow=1 and inexact=1.
- Back-to-back: 8 consecutive valid requests with random normals.
  - Expect 8 consecutive out_valid cycles, bit-exact against a reference model with flush-to-zero.
- Reset mid-flight: issue 3 requests, assert rst at the 2nd cycle after the first.
  - Expect out_valid=0 for the following 6 cycles, and result=0 and flags=0 once rst has been applied.
- clr_flags in the same cycle as a valid overflow output: flags equal {0,1,0,1} for that lane.
  - Then clr_flags alone: flags=0.
